// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the alarm-clock panel input conditioner.
//   btn_state_t     : per-button event FSM state (IDLE -> DELAY -> REPEAT)
//   pulse_phase_t   : phase of the fixed-width event pulse generator
//   cnt_width()     : width of a counter that must hold any of the timing values
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_HIGH = 2'd1,
        P_GAP  = 2'd2
    } pulse_phase_t;

    // Bits needed to count up to the largest of the four timing values.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// One push-button channel: 2-flop synchroniser, debouncer, press/auto-repeat
// event FSM and fixed-width pulse generator.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   raw_n      : raw key from the pin, low = pressed
//   freeze     : holds the auto-repeat counter and suppresses repeat events
//   pressed    : debounced key level (1 = pressed)
//   pulse      : event pulses, PULSE_CYCLES high then at least PULSE_CYCLES low
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter bit REPEAT_EN            = 1'b1,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int PULSE_CYCLES         = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    input  logic freeze,
    output logic pressed,
    output logic pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                  REPEAT_PERIOD_CYCLES, PULSE_CYCLES);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY_CYCLES);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD_CYCLES);
    localparam logic [CW-1:0] PL_LAST  = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    // ---------------- synchroniser + debouncer ----------------
    logic          sync1_reg, sync2_reg;
    logic          deb_reg;
    logic [CW-1:0] dcnt_reg;
    logic          sync_pressed;

    assign sync_pressed = ~sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            deb_reg   <= 1'b0;
            dcnt_reg  <= '0;
        end else begin
            sync1_reg <= raw_n;
            sync2_reg <= sync1_reg;
            if (sync_pressed != deb_reg) begin
                if (dcnt_reg == DB_LAST) begin
                    deb_reg  <= ~deb_reg;
                    dcnt_reg <= '0;
                end else begin
                    dcnt_reg <= dcnt_reg + ONE;
                end
            end else begin
                dcnt_reg <= '0;
            end
        end
    end

    assign pressed = deb_reg;

    // ---------------- event FSM ----------------
    // The hold counter starts at 1 on the press cycle so that the first
    // repeat lands exactly REPEAT_DELAY_CYCLES after the press event.
    btn_state_t    state_reg, state_next;
    logic [CW-1:0] hcnt_reg, hcnt_next;
    logic          ev_reg, ev_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            ev_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            ev_reg    <= ev_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        ev_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (deb_reg) begin
                    ev_next    = 1'b1;
                    hcnt_next  = ONE;
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (!deb_reg) begin
                    state_next = IDLE;
                    hcnt_next  = '0;
                end else if (!freeze) begin
                    if (hcnt_reg == RD_LAST) begin
                        // Without repeat the counter parks here until release.
                        if (REPEAT_EN) begin
                            ev_next    = 1'b1;
                            hcnt_next  = ONE;
                            state_next = REPEAT;
                        end
                    end else begin
                        hcnt_next = hcnt_reg + ONE;
                    end
                end
            end
            REPEAT: begin
                if (!deb_reg) begin
                    state_next = IDLE;
                    hcnt_next  = '0;
                end else if (!freeze) begin
                    if (hcnt_reg == RP_LAST) begin
                        ev_next   = 1'b1;
                        hcnt_next = ONE;
                    end else begin
                        hcnt_next = hcnt_reg + ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                hcnt_next  = '0;
            end
        endcase
    end

    // ---------------- pulse generator ----------------
    // One-deep pending slot: an event during HIGH/GAP is remembered and
    // issued at the end of the gap; extra events while pending are dropped.
    pulse_phase_t  phase_reg, phase_next;
    logic [CW-1:0] pcnt_reg, pcnt_next;
    logic          pend_reg, pend_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= P_IDLE;
            pcnt_reg  <= '0;
            pend_reg  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            pcnt_reg  <= pcnt_next;
            pend_reg  <= pend_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        pcnt_next  = pcnt_reg;
        pend_next  = pend_reg;
        case (phase_reg)
            P_IDLE: begin
                if (ev_reg) begin
                    phase_next = P_HIGH;
                    pcnt_next  = ONE;
                end
            end
            P_HIGH: begin
                if (ev_reg) pend_next = 1'b1;
                if (pcnt_reg == PL_LAST) begin
                    phase_next = P_GAP;
                    pcnt_next  = ONE;
                end else begin
                    pcnt_next = pcnt_reg + ONE;
                end
            end
            P_GAP: begin
                if (pcnt_reg == PL_LAST) begin
                    pend_next = 1'b0;
                    if (pend_reg || ev_reg) begin
                        phase_next = P_HIGH;
                        pcnt_next  = ONE;
                    end else begin
                        phase_next = P_IDLE;
                        pcnt_next  = '0;
                    end
                end else begin
                    pcnt_next = pcnt_reg + ONE;
                    if (ev_reg) pend_next = 1'b1;
                end
            end
            default: begin
                phase_next = P_IDLE;
                pcnt_next  = '0;
                pend_next  = 1'b0;
            end
        endcase
    end

    assign pulse = (phase_reg == P_HIGH);

endmodule

// File: rtl/btn_conditioner.sv
// Alarm-clock panel input conditioner. Synchronises and debounces the raw
// active-low keys and slide switches; keys become event pulses (UP/DOWN with
// auto-repeat), switches become clean levels.
// Ports:
//   clk_clk, reset_reset_n          : clock, asynchronous active-low reset
//   btn_up_n/btn_down_n/btn_set_n   : raw keys, low = pressed
//   swc_sel_raw/swc_activate_raw    : raw slide switches
//   btn_up_o/btn_down_o/btn_set_o   : event pulses (active-high)
//   swc_sel_o/swc_activate_o        : debounced switch levels
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter int PULSE_CYCLES         = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic btn_up_n,
    input  logic btn_down_n,
    input  logic btn_set_n,
    input  logic swc_sel_raw,
    input  logic swc_activate_raw,
    output logic btn_up_o,
    output logic btn_down_o,
    output logic btn_set_o,
    output logic swc_sel_o,
    output logic swc_activate_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES, 2, 2, 2);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    // SET takes no part in the UP+DOWN interlock.
    localparam logic [2:0] NOT_INTERLOCKED = 3'b100;

    // ---------------- buttons: index 0 = UP, 1 = DOWN, 2 = SET ----------------
    logic [2:0] key_raw_n;
    logic [2:0] key_pressed;
    logic [2:0] key_pulse;
    logic       interlock;

    assign key_raw_n = {btn_set_n, btn_down_n, btn_up_n};
    assign interlock = &(key_pressed | NOT_INTERLOCKED);

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        localparam bit RPT = (gi != 2);
        btn_channel #(
            .REPEAT_EN            (RPT),
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .PULSE_CYCLES         (PULSE_CYCLES)
        ) u_chan (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .raw_n   (key_raw_n[gi]),
            .freeze  (interlock & RPT),
            .pressed (key_pressed[gi]),
            .pulse   (key_pulse[gi])
        );
    end

    assign btn_up_o   = key_pulse[0];
    assign btn_down_o = key_pulse[1];
    assign btn_set_o  = key_pulse[2];

    // ---------------- switches: index 0 = SEL, 1 = ACTIVATE ----------------
    // Two register stages after the debouncer give switches the same
    // input-to-output latency as a key's first event.
    logic [1:0] sw_raw;
    logic [1:0] sw_level;

    assign sw_raw = {swc_activate_raw, swc_sel_raw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sw
        logic          sync1_reg, sync2_reg, deb_reg, dly_reg, out_reg;
        logic [DW-1:0] dcnt_reg;

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                deb_reg   <= 1'b0;
                dcnt_reg  <= '0;
                dly_reg   <= 1'b0;
                out_reg   <= 1'b0;
            end else begin
                sync1_reg <= sw_raw[gi];
                sync2_reg <= sync1_reg;
                if (sync2_reg != deb_reg) begin
                    if (dcnt_reg == DB_LAST) begin
                        deb_reg  <= ~deb_reg;
                        dcnt_reg <= '0;
                    end else begin
                        dcnt_reg <= dcnt_reg + DW'(1);
                    end
                end else begin
                    dcnt_reg <= '0;
                end
                dly_reg <= deb_reg;
                out_reg <= dly_reg;
            end
        end

        assign sw_level[gi] = out_reg;
    end

    assign swc_sel_o      = sw_level[0];
    assign swc_activate_o = sw_level[1];

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up_n = 1'b1, down_n = 1'b1, set_n = 1'b1, sel = 1'b0, act = 1'b0;
    logic up_o, down_o, set_o, sel_o, act_o;

    btn_conditioner #(
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .PULSE_CYCLES         (PL)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .btn_up_n         (up_n),
        .btn_down_n       (down_n),
        .btn_set_n        (set_n),
        .swc_sel_raw      (sel),
        .swc_activate_raw (act),
        .btn_up_o         (up_o),
        .btn_down_o       (down_o),
        .btn_set_o        (set_o),
        .swc_sel_o        (sel_o),
        .swc_activate_o   (act_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;      // active clock edges since reset release

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0b expected %0b", tag, t, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs in "active" sense: index 0..2 = UP/DOWN/SET pressed, 3..4 = SEL/ACT.
    // An input's clean level flips once its synchronised value has disagreed
    // with it for D consecutive samples; samples reach the debouncer two
    // edges after they are taken.
    bit hist [5][D+1];   // hist[i][k] = sample taken k+1 edges ago
    bit deb [5];
    bit deb_prev [3];
    bit held [3];
    int hold_t [3];      // un-frozen edges since the press event
    bit ev_q [3];        // event decided on the previous edge
    int pstart [3];      // edge at which the latest pulse started
    bit pend [3];
    bit mout [3];
    bit sw_d1 [2];
    bit sw_out [2];

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 5; i++) begin
            deb[i] = 1'b0;
            for (int k = 0; k <= D; k++) hist[i][k] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            deb_prev[c] = 1'b0; held[c] = 1'b0; hold_t[c] = 0;
            ev_q[c] = 1'b0; pstart[c] = -1000; pend[c] = 1'b0; mout[c] = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            sw_d1[j] = 1'b0; sw_out[j] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit s [5];
        bit nd [5];
        bit ev [3];
        bit stable, frozen;
        t++;
        s[0] = ~up_n; s[1] = ~down_n; s[2] = ~set_n; s[3] = sel; s[4] = act;
        for (int i = 0; i < 5; i++) begin
            stable = 1'b1;
            for (int k = 1; k <= D; k++) if (hist[i][k] == deb[i]) stable = 1'b0;
            nd[i] = stable ? ~deb[i] : deb[i];
        end
        frozen = deb[0] & deb[1];
        for (int c = 0; c < 3; c++) begin
            ev[c] = 1'b0;
            if (!deb[c]) begin
                held[c] = 1'b0;
            end else if (!deb_prev[c]) begin
                ev[c] = 1'b1; held[c] = 1'b1; hold_t[c] = 0;
            end else if (held[c] && c < 2 && !frozen) begin
                hold_t[c]++;
                if (hold_t[c] >= RD && (hold_t[c] - RD) % RP == 0) ev[c] = 1'b1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (t >= pstart[c] + 2*PL) begin
                if (pend[c] || ev_q[c]) begin
                    pstart[c] = t; pend[c] = 1'b0;
                end
            end else if (ev_q[c]) begin
                pend[c] = 1'b1;
            end
            mout[c] = (t >= pstart[c]) && (t < pstart[c] + PL);
        end
        for (int j = 0; j < 2; j++) begin
            sw_out[j] = sw_d1[j];
            sw_d1[j]  = deb[3+j];
        end
        for (int c = 0; c < 3; c++) begin
            deb_prev[c] = deb[c];
            ev_q[c] = ev[c];
        end
        for (int i = 0; i < 5; i++) begin
            deb[i] = nd[i];
            for (int k = D; k >= 1; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = s[i];
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        check("up_o",   up_o,   mout[0]);
        check("down_o", down_o, mout[1]);
        check("set_o",  set_o,  mout[2]);
        check("sel_o",  sel_o,  sw_out[0]);
        check("act_o",  act_o,  sw_out[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic txn(input string name);
        $display("TXN %-14s t=%0d checks=%0d errors=%0d", name, t, checks, errors);
    endtask

    int seen;
    logic prev_o;

    initial begin
        model_reset();
        run(3);
        rst_n = 1'b1;
        run(9);
        txn("reset");

        // UP held: press event then repeats
        up_n = 1'b0; run(60); up_n = 1'b1; run(20);
        txn("up_repeat");

        // SET: short bounces ignored, long hold gives a single pulse
        for (int g = 0; g < 3; g++) begin
            set_n = 1'b0; run(3); set_n = 1'b1; run(3);
        end
        set_n = 1'b0; run(40); set_n = 1'b1; run(15);
        txn("set_glitch_hold");

        // UP+DOWN interlock, then DOWN released
        up_n = 1'b0; run(2); down_n = 1'b0; run(48);
        down_n = 1'b1; run(60); up_n = 1'b1; run(20);
        txn("interlock");

        // Release UP one cycle after a repeat pulse rises
        up_n = 1'b0; seen = 0; prev_o = 1'b0;
        for (int i = 0; i < 80 && seen < 2; i++) begin
            step();
            if (up_o && !prev_o) seen++;
            prev_o = up_o;
        end
        check("up_repeat_seen", (seen == 2), 1'b1);
        step(); up_n = 1'b1; run(30);
        txn("release_mid");

        // ACTIVATE switch with a short low glitch
        act = 1'b1; run(25); act = 1'b0; run(3); act = 1'b1; run(20);
        sel = 1'b1; run(12);
        txn("switches");

        // Reset while DOWN pulse is high; key stays held through reset
        down_n = 1'b0; prev_o = 1'b0;
        for (int i = 0; i < 40 && !prev_o; i++) begin
            step();
            prev_o = down_o;
        end
        check("down_pulse_seen", prev_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_down", down_o, 1'b0);
        check("async_rst_act", act_o, 1'b0);
        run(2);
        rst_n = 1'b1;
        run(40); down_n = 1'b1; act = 1'b0; sel = 1'b0; run(15);
        txn("reset_mid");

        // Randomised segments: bouncy or steady inputs, random lengths
        for (int seg = 0; seg < 120; seg++) begin
            int len, odds;
            len  = $urandom_range(5, 60);
            odds = ($urandom_range(0, 3) == 0) ? 4 : 40;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(1, odds) == 1) up_n   = ~up_n;
                if ($urandom_range(1, odds) == 1) down_n = ~down_n;
                if ($urandom_range(1, odds) == 1) set_n  = ~set_n;
                if ($urandom_range(1, odds) == 1) sel    = ~sel;
                if ($urandom_range(1, odds) == 1) act    = ~act;
                step();
            end
            $display("TXN rand%-10d t=%0d len=%0d odds=%0d in=%b%b%b%b%b checks=%0d errors=%0d",
                     seg, t, len, odds, up_n, down_n, set_n, sel, act, checks, errors);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
